muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle controller and datapath for MIPS MULT/DIV; loads HI/LO.
- Receives one-cycle start pulses from the main control unit (multCtrl/divCtrl path) and operands from registers A/B.
- Performs one iteration per cycle: radix-2 Booth multiply or restoring divide.
- Holds busy so the control unit stalls, then issues one-cycle HI/LO write strobes with the results.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits.
- ITER, WIDTH, iteration count for both operations.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start_mult  in  1  one-cycle request: signed multiply
- start_div  in  1  one-cycle request: signed divide
- op_a  in  WIDTH  multiplicand / dividend (register A)
- op_b  in  WIDTH  multiplier / divisor (register B)
- busy  out  1  operation in progress; control unit stalls
- done  out  1  one-cycle pulse, result written
- div_zero  out  1  one-cycle pulse, divisor was zero (exception to control unit)
- hi_out  out  WIDTH  HI result (product high word / remainder)
- lo_out  out  WIDTH  LO result (product low word / quotient)
- hi_write  out  1  HI register load strobe
- lo_write  out  1  LO register load strobe

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; iteration counter = 0.
  - All outputs = 0, including hi_out and lo_out.
  - An operation in flight is abandoned with no write strobe.
- States: IDLE, MULT, DIV, FINISH, DZERO.
- IDLE:
  - start_mult=1: capture op_a/op_b, go to MULT.
  - start_div=1 with op_b≠0: capture operands, go to DIV.
  - start_div=1 with op_b=0: go to DZERO.
  - start_mult and start_div both 1: multiply wins; the divide request is dropped.
- Captured operands are frozen; changes on op_a/op_b after the start cycle have no effect.
- busy = 1 in MULT, DIV, FINISH and DZERO; 0 only in IDLE.
- Start pulses while busy are ignored; they are not queued.
- MULT:
  - Signed Booth on a 2*WIDTH+1-bit accumulator.
  - Examine bit pair {q0,q-1}: 01 → add multiplicand to the upper half; 10 → subtract it; 00/11 → no change.
  - Then arithmetic shift right by 1.
  - ITER cycles, counter 0..ITER-1, then FINISH.
- DIV:
  - Restoring divide on unsigned magnitudes |a| and |b|, ITER cycles, then FINISH.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - The most-negative dividend uses magnitude 0x80000000 as unsigned.
  - −2^31 / −1 gives LO=0x80000000, HI=0.
- FINISH (one cycle):
  - hi_out and lo_out are driven with the result.
  - hi_write = lo_write = done = 1.
  - Next state is IDLE.
- DZERO (one cycle):
  - div_zero = 1.
  - No write strobes; hi_out and lo_out keep their previous values.
  - Next state is IDLE.
- Latency, with start sampled at edge 0:
  - Multiply/divide: busy from cycle 1, iterations in cycles 1..ITER, strobes in cycle ITER+1, IDLE at ITER+2.
  - Divide-by-zero: div_zero in cycle 1.
- hi_out and lo_out are registered and hold the last result until the next FINISH.
- A new start is accepted in the first IDLE cycle after FINISH or DZERO (back-to-back operations allowed).

Optional Feature:
- Macro: MULDIV_UNSIGNED_EN
- Defined:
  - Adds input is_unsigned (1 bit), sampled with the start pulse.
  - When 1: MULTU/DIVU semantics. Multiply uses a zero-extended accumulator with unsigned add-shift; divide skips magnitude and sign correction.
  - −2^31 / −1 is then the unsigned 0x80000000 / 0xFFFFFFFF, giving LO=0, HI=0x80000000.
- Undefined: the port is absent and all operations are signed.

Decomposition:
- Package muldiv_pkg holds:
  - State enum (IDLE, MULT, DIV, FINISH, DZERO).
  - MULDIV_WIDTH = 32.
  - Funct constants: FUNCT_MULT = 6'h18, FUNCT_MULTU = 6'h19, FUNCT_DIV = 6'h1A, FUNCT_DIVU = 6'h1B.
- One sub-module, muldiv_datapath:
  - Contains the accumulator/remainder and quotient shift registers, the adder/subtractor, and sign fix-up.
  - Controlled by step_mult, step_div, load and finalize from the FSM.
- The FSM and iteration counter stay in muldiv_sequencer.

Test Plan:
- start_mult, a=7, b=0xFFFFFFFD (−3) → FINISH at cycle 33; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; done/hi_write/lo_write high for exactly one cycle; busy cycles 1..33.
- start_div, a=100, b=7 → lo_out=14, hi_out=2 at cycle 33. Then a=0xFFFFFFF9 (−7), b=2 → lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
- start_div, a=5, b=0 after a prior result → div_zero pulse in cycle 1, no write strobes, hi_out/lo_out unchanged, busy low in cycle 2.
- start_mult and start_div together (a=3, b=4) → multiply result hi=0, lo=12; no div_zero. A start_div pulse at cycle 10 of that operation is ignored; operands changed at cycle 5 do not affect the result.
- Edge case: start_div a=0x80000000, b=0xFFFFFFFF → lo_out=0x80000000, hi_out=0.
- Reset mid-operation: reset asserted at cycle 15 of a multiply → outputs 0 immediately, no strobe, IDLE after release. A new start_mult (a=2, b=3) then completes with lo_out=6.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencer: FSM state encoding, default width, funct codes.
// Pure declarations; no timing or flow-control behaviour.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    FINISH,
    DZERO
  } muldivState_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Booth multiply / restoring divide datapath: one iteration per step strobe, result registered on finalize.
// Latency set entirely by the controlling FSM; no flow control of its own, outputs hold until the next finalize.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             loadMult,
  input  logic             loadUnsigned,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             step_mult,
  input  logic             step_div,
  input  logic             finalize,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut
);

  // accHi carries one guard bit so a most-negative multiplicand cannot overflow the upper half.
  logic [WIDTH:0]   accHi, addend, boothSum, multHi, divShift, divDiff, divHi;
  logic [WIDTH-1:0] accLo, mcand, multLo, divLo, quoFix, remFix, hiRes, loRes, aMag, bMag;
  logic             accQm1, signedOp, quoNeg, remNeg, divGe;

  always_comb begin
    aMag = (loadUnsigned || !opA[WIDTH-1]) ? opA : -opA;
    bMag = (loadUnsigned || !opB[WIDTH-1]) ? opB : -opB;

    addend   = signedOp ? {mcand[WIDTH-1], mcand} : {1'b0, mcand};
    boothSum = accHi;
    if (signedOp) begin
      if (accLo[0] && !accQm1) begin
        boothSum = accHi - addend;
      end else if (!accLo[0] && accQm1) begin
        boothSum = accHi + addend;
      end
    end else if (accLo[0]) begin
      boothSum = accHi + addend;
    end
    multHi = {signedOp & boothSum[WIDTH], boothSum[WIDTH:1]};
    multLo = {boothSum[0], accLo[WIDTH-1:1]};

    // Restoring step: remainder in accHi, dividend bits shift out of accLo as quotient bits shift in.
    divShift = {accHi[WIDTH-1:0], accLo[WIDTH-1]};
    divDiff  = divShift - {1'b0, mcand};
    divGe    = ~divDiff[WIDTH];
    divHi    = divGe ? divDiff : divShift;
    divLo    = {accLo[WIDTH-2:0], divGe};

    quoFix = quoNeg ? -divLo : divLo;
    remFix = remNeg ? -divHi[WIDTH-1:0] : divHi[WIDTH-1:0];
    hiRes  = step_mult ? multHi[WIDTH-1:0] : remFix;
    loRes  = step_mult ? multLo : quoFix;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      accHi    <= '0;
      accLo    <= '0;
      accQm1   <= 1'b0;
      mcand    <= '0;
      signedOp <= 1'b0;
      quoNeg   <= 1'b0;
      remNeg   <= 1'b0;
      hiOut    <= '0;
      loOut    <= '0;
    end else begin
      if (load) begin
        accHi    <= '0;
        accQm1   <= 1'b0;
        signedOp <= !loadUnsigned;
        if (loadMult) begin
          accLo  <= opB;
          mcand  <= opA;
          quoNeg <= 1'b0;
          remNeg <= 1'b0;
        end else begin
          accLo  <= aMag;
          mcand  <= bMag;
          quoNeg <= !loadUnsigned && (opA[WIDTH-1] ^ opB[WIDTH-1]);
          remNeg <= !loadUnsigned && opA[WIDTH-1];
        end
      end else if (step_mult) begin
        accHi  <= multHi;
        accLo  <= multLo;
        accQm1 <= accLo[0];
      end else if (step_div) begin
        accHi <= divHi;
        accLo <= divLo;
      end
      // The last iteration's result is fixed up and registered in the same edge that enters FINISH.
      if (finalize) begin
        hiOut <= hiRes;
        loOut <= loRes;
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// MIPS MULT/DIV sequencer: busy for ITER+1 cycles after a start, then one-cycle HI/LO write strobes (divide-by-zero: div_zero in cycle 1).
// Starts while busy are dropped, not queued; define MULDIV_UNSIGNED_EN to add the is_unsigned input for MULTU/DIVU.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
`ifdef MULDIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hi_write,
  output logic             lo_write
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  muldivState_t     state, nextState;
  logic [CNT_W-1:0] iterCnt;
  logic             lastIter, divisorZero, opUnsigned;
  logic             load, loadMult, stepMult, stepDiv, finalize;

`ifdef MULDIV_UNSIGNED_EN
  assign opUnsigned = is_unsigned;
`else
  assign opUnsigned = 1'b0;
`endif

  assign lastIter    = (iterCnt == CNT_W'(ITER - 1));
  assign divisorZero = (op_b == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iterCnt <= '0;
    end else if (state == MULT || state == DIV) begin
      iterCnt <= iterCnt + 1'b1;
    end else begin
      iterCnt <= '0;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start_mult) begin
          nextState = MULT;
        end else if (start_div) begin
          nextState = divisorZero ? DZERO : DIV;
        end
      end
      MULT:    if (lastIter) nextState = FINISH;
      DIV:     if (lastIter) nextState = FINISH;
      FINISH:  nextState = IDLE;
      DZERO:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = (state == FINISH);
    hi_write = (state == FINISH);
    lo_write = (state == FINISH);
    div_zero = (state == DZERO);
    load     = (state == IDLE) && (start_mult || (start_div && !divisorZero));
    loadMult = start_mult;
    stepMult = (state == MULT);
    stepDiv  = (state == DIV);
    finalize = (stepMult || stepDiv) && lastIter;
  end

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .loadMult    (loadMult),
    .loadUnsigned(opUnsigned),
    .opA         (op_a),
    .opB         (op_b),
    .step_mult   (stepMult),
    .step_div    (stepDiv),
    .finalize    (finalize),
    .hiOut       (hi_out),
    .loOut       (lo_out)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO pushed at start, popped when done pulses.
// Also checks cycle timing, ignored starts, operand freeze, divide-by-zero and async reset.
module tb_muldiv_sequencer;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } resT;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_mult, start_div;
  logic [31:0] op_a, op_b;
  logic        busy, done, div_zero, hi_write, lo_write;
  logic [31:0] hi_out, lo_out;
`ifdef MULDIV_UNSIGNED_EN
  logic        is_unsigned = 1'b0;
`endif

  int  vecCount  = 0;
  int  missCount = 0;
  resT sbQ[$];

  always #5 clock = ~clock;

  muldiv_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .start_mult(start_mult),
    .start_div (start_div),
`ifdef MULDIV_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .hi_write  (hi_write),
    .lo_write  (lo_write)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic resT model(input logic isMult, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    resT    res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (isMult) begin
      p      = sa * sb;
      res.hi = p[63:32];
      res.lo = p[31:0];
    end else begin
      q      = sa / sb;
      r      = sa % sb;
      res.hi = r[31:0];
      res.lo = q[31:0];
    end
    return res;
  endfunction

  // Result scoreboard and strobe consistency, sampled on the falling edge.
  always @(negedge clock) begin
    resT e;
    if (reset && (done || hi_write || lo_write)) begin
      checkVal("hi_write_vs_done", {63'b0, hi_write}, {63'b0, done});
      checkVal("lo_write_vs_done", {63'b0, lo_write}, {63'b0, done});
      if (done) begin
        if (sbQ.size() == 0) begin
          checkVal("spurious_done", {63'b0, done}, 64'd0);
        end else begin
          e = sbQ.pop_front();
          checkVal("result_hi_lo", {hi_out, lo_out}, {e.hi, e.lo});
        end
      end
    end
  end

  // Called at a falling edge while the DUT is idle; returns at the falling edge of the first idle cycle.
  task automatic runOp(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       input int pokeCyc, input int chgCyc);
    int          cyc, doneCyc, doneCnt, dzCyc, dzCnt;
    logic        dzExpected;
    logic [63:0] prevOut;
    dzExpected = !m && d && (b == 32'd0);
    prevOut    = {hi_out, lo_out};
    start_mult = m;
    start_div  = d;
    op_a       = a;
    op_b       = b;
    if (m || (d && b != 32'd0)) sbQ.push_back(model(m, a, b));
    @(negedge clock);
    start_mult = 1'b0;
    start_div  = 1'b0;
    cyc = 1; doneCyc = 0; doneCnt = 0; dzCyc = 0; dzCnt = 0;
    while (busy && cyc < 200) begin
      if (done) begin doneCnt++; doneCyc = cyc; end
      if (div_zero) begin dzCnt++; dzCyc = cyc; end
      start_div = (cyc == pokeCyc);
      if (cyc == chgCyc) begin
        op_a = $urandom;
        op_b = $urandom;
      end
      @(negedge clock);
      cyc++;
    end
    start_div = 1'b0;
    if (dzExpected) begin
      checkVal("dz_idle_cycle", 64'(cyc), 64'd2);
      checkVal("dz_pulse_cycle", 64'(dzCyc), 64'd1);
      checkVal("dz_pulse_count", 64'(dzCnt), 64'd1);
      checkVal("dz_no_write", 64'(doneCnt), 64'd0);
      checkVal("dz_hold_hi_lo", {hi_out, lo_out}, prevOut);
    end else begin
      checkVal("idle_cycle", 64'(cyc), 64'd34);
      checkVal("done_cycle", 64'(doneCyc), 64'd33);
      checkVal("done_count", 64'(doneCnt), 64'd1);
      checkVal("no_div_zero", 64'(dzCnt), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rm;
    reset      = 1'b0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = 32'd0;
    op_b       = 32'd0;
    repeat (2) @(negedge clock);
    checkVal("reset_state", {57'b0, busy, done, div_zero, hi_write, lo_write, 2'b0},
             64'd0);
    checkVal("reset_hi_lo", {hi_out, lo_out}, 64'd0);
    reset = 1'b1;
    @(negedge clock);

    runOp(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, -1, -1);
    runOp(1'b0, 1'b1, 32'd100, 32'd7, -1, -1);
    runOp(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, -1, -1);
    runOp(1'b0, 1'b1, 32'd5, 32'd0, -1, -1);
    runOp(1'b1, 1'b1, 32'd3, 32'd4, 10, 5);
    runOp(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, -1, -1);
    runOp(1'b1, 1'b0, 32'h80000000, 32'h80000000, -1, -1);
    runOp(1'b1, 1'b0, 32'h80000000, 32'h7FFFFFFF, -1, -1);
    runOp(1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000000, -1, -1);
    for (int i = 0; i < 6; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if (i[0]) rb = rb >> 20;
      if (rb == 32'd0) rb = 32'd1;
      runOp(rm, !rm, ra, rb, -1, -1);
    end
    runOp(1'b1, 1'b0, 32'd3, 32'd4, -1, -1);

    // Abandon a multiply at cycle 15; no result is expected for it.
    start_mult = 1'b1;
    op_a       = 32'h12345678;
    op_b       = 32'h9ABCDEF0;
    @(negedge clock);
    start_mult = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b0;
    #1;
    checkVal("midop_reset_ctl", {59'b0, busy, done, div_zero, hi_write, lo_write}, 64'd0);
    checkVal("midop_reset_hi_lo", {hi_out, lo_out}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkVal("post_reset_idle", {63'b0, busy}, 64'd0);
    runOp(1'b1, 1'b0, 32'd2, 32'd3, -1, -1);
    checkVal("post_reset_lo", {32'd0, lo_out}, 64'd6);

    repeat (40) @(negedge clock);
    checkVal("scoreboard_drained", 64'(sbQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
